// File: rtl/vlane_wb_buffer_if.sv
// Handshake bundle between the vector lane ALU, the writeback buffer and the
// register-file write port. Signal names carry the buffer's point of view.
interface vlane_wb_buffer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_BITS   = 5
);
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [DATA_WIDTH-1:0]     in_data_i;
  logic                      in_mask_i;
  logic                      in_last_i;
  logic [2:0]                in_sew_i;
  logic [REG_BITS-1:0]       in_dst_i;
  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic [DATA_WIDTH-1:0]     wb_data_o;
  logic [REG_BITS-1:0]       wb_addr_o;
  logic [DATA_WIDTH/8-1:0]   wb_be_o;

  modport master (
    output in_valid_i, in_data_i, in_mask_i, in_last_i, in_sew_i, in_dst_i, wb_ready_i,
    input  in_ready_o, wb_valid_o, wb_data_o, wb_addr_o, wb_be_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_mask_i, in_last_i, in_sew_i, in_dst_i, wb_ready_i,
    output in_ready_o, wb_valid_o, wb_data_o, wb_addr_o, wb_be_o
  );
endinterface

// File: rtl/vlane_wb_buffer.sv
// Vector lane writeback buffer: FIFO toward the VRF write port, with compare
// results packed across beats into a single mask word per destination.
module vlane_wb_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int REG_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  vlane_wb_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   busy_o
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = $clog2(DATA_WIDTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FLUSH = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [REG_BITS-1:0]   dst_q, dst_d;

  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [REG_BITS-1:0]   mem_addr_q [DEPTH];
  logic [BW-1:0]         mem_be_q   [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;

  logic [PW-1:0]         n_s, ptr_ins_s;
  logic [DATA_WIDTH-1:0] lane_mask_s, acc_ins_s;
  logic                  full_s, pop_s, can_push_s, interrupt_s, ins_done_s;
  logic                  push_s, in_ready_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic [REG_BITS-1:0]   push_addr_s;
  logic [BW-1:0]         push_be_s;
  logic                  sew_unused_s;

  function automatic logic [BW-1:0] be_from_ptr(input logic [PW-1:0] p);
    logic [PW:0] nb;
    nb = ({1'b0, p} + (PW+1)'(7)) >> 3;
    return ~({BW{1'b1}} << nb);
  endfunction

  assign sew_unused_s = bus.in_sew_i[2];
  assign n_s          = PW'(DATA_WIDTH >> (32'd3 + {30'd0, bus.in_sew_i[1:0]}));
  assign lane_mask_s  = {DATA_WIDTH{1'b1}} >> (PW'(DATA_WIDTH) - n_s);
  assign acc_ins_s    = acc_q | ((bus.in_data_i & lane_mask_s) << ptr_q);
  assign ptr_ins_s    = ptr_q + n_s;
  assign ins_done_s   = bus.in_last_i | (ptr_ins_s == PW'(DATA_WIDTH));
  assign full_s       = (count_q == CW'(DEPTH));
  assign pop_s        = (count_q != CW'(0)) & bus.wb_ready_i;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign can_push_s   = ~full_s | pop_s;
  assign interrupt_s  = (state_q == ACCUM) & bus.in_valid_i &
                        (~bus.in_mask_i | (bus.in_dst_i != dst_q));

  // Packing FSM next state, FIFO push request and input ready.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ptr_d       = ptr_q;
    dst_d       = dst_q;
    push_s      = 1'b0;
    push_data_s = acc_q;
    push_addr_s = dst_q;
    push_be_s   = be_from_ptr(ptr_q);
    in_ready_s  = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        // Mask beats never need a slot on accept; a completed word can wait in FLUSH.
        in_ready_s = (can_push_s | bus.in_mask_i) & ~interrupt_s;
        if (interrupt_s) begin
          if (can_push_s) begin
            push_s  = 1'b1;
            acc_d   = '0;
            ptr_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end else if (bus.in_valid_i && !bus.in_mask_i) begin
          if (can_push_s) begin
            push_s      = 1'b1;
            push_data_s = bus.in_data_i;
            push_addr_s = bus.in_dst_i;
            push_be_s   = {BW{1'b1}};
          end else begin
            push_s = 1'b0;
          end
        end else if (bus.in_valid_i) begin
          acc_d = acc_ins_s;
          ptr_d = ptr_ins_s;
          dst_d = (state_q == IDLE) ? bus.in_dst_i : dst_q;
          if (ins_done_s) begin
            push_data_s = acc_ins_s;
            push_addr_s = dst_d;
            push_be_s   = be_from_ptr(ptr_ins_s);
            if (can_push_s) begin
              push_s  = 1'b1;
              acc_d   = '0;
              ptr_d   = '0;
              state_d = IDLE;
            end else begin
              state_d = FLUSH;
            end
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      FLUSH: begin
        if (can_push_s) begin
          push_s  = 1'b1;
          acc_d   = '0;
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packing FSM and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ptr_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ptr_q   <= ptr_d;
      dst_q   <= dst_d;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_addr_q[i] <= '0;
        mem_be_q[i]   <= '0;
      end
    end else begin
      if (push_s) begin
        mem_data_q[wr_ptr_q] <= push_data_s;
        mem_addr_q[wr_ptr_q] <= push_addr_s;
        mem_be_q[wr_ptr_q]   <= push_be_s;
        wr_ptr_q             <= wr_ptr_q + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      end
      count_q <= count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  assign bus.in_ready_o = in_ready_s;
  assign bus.wb_valid_o = (count_q != CW'(0));
  assign bus.wb_data_o  = mem_data_q[rd_ptr_q];
  assign bus.wb_addr_o  = mem_addr_q[rd_ptr_q];
  assign bus.wb_be_o    = mem_be_q[rd_ptr_q];
  assign count_o        = count_q;
  assign busy_o         = (count_q != CW'(0)) | (ptr_q != PW'(0));
endmodule

// File: tb/tb_vlane_wb_buffer.sv
// Directed bench for vlane_wb_buffer: per-cycle vector table plus hand-written
// sequences for backpressure, full-word auto-emit, FLUSH and mid-pack reset.
module tb_vlane_wb_buffer;
  logic       clk;
  logic       rst;
  logic [2:0] count;
  logic       busy;

  vlane_wb_buffer_if #(.DATA_WIDTH(64), .REG_BITS(5)) bus ();

  vlane_wb_buffer #(.DATA_WIDTH(64), .DEPTH(4), .REG_BITS(5)) dut (
    .clk(clk), .rst(rst), .bus(bus), .count_o(count), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, m, l;
    logic [2:0]  sew;
    logic [4:0]  dst;
    logic [63:0] data;
    logic        wr;
    logic        e_rdy, e_wv;
    logic [63:0] e_wd;
    logic [4:0]  e_wa;
    logic [7:0]  e_be;
    logic [2:0]  e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t         vecs[$];
  logic [76:0]  got[$];
  logic [76:0]  exp_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           k;

  task automatic chk(input string name, input logic [76:0] act, input logic [76:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic l, input logic [2:0] sew,
                       input logic [4:0] dst, input logic [63:0] data, input logic wr);
    bus.in_valid_i = v;
    bus.in_mask_i  = m;
    bus.in_last_i  = l;
    bus.in_sew_i   = sew;
    bus.in_dst_i   = dst;
    bus.in_data_i  = data;
    bus.wb_ready_i = wr;
  endtask

  task automatic cycle();
    if (bus.wb_valid_o && bus.wb_ready_i)
      got.push_back({bus.wb_be_o, bus.wb_addr_o, bus.wb_data_o});
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic m, input logic l, input logic [2:0] sew,
                     input logic [4:0] dst, input logic [63:0] data, input logic wr,
                     input logic e_rdy, input logic e_wv, input logic [63:0] e_wd,
                     input logic [4:0] e_wa, input logic [7:0] e_be, input logic [2:0] e_cnt,
                     input logic e_busy);
    vec_t t;
    t.v = v; t.m = m; t.l = l; t.sew = sew; t.dst = dst; t.data = data; t.wr = wr;
    t.e_rdy = e_rdy; t.e_wv = e_wv; t.e_wd = e_wd; t.e_wa = e_wa; t.e_be = e_be;
    t.e_cnt = e_cnt; t.e_busy = e_busy;
    vecs.push_back(t);
  endtask

  task automatic compare_got(input string name);
    chk({name, "_n"}, 77'(got.size()), 77'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(name, got[i], exp_q[i]);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_wv",   77'(bus.wb_valid_o), 77'd0);
    chk("rst_wd",   77'(bus.wb_data_o),  77'd0);
    chk("rst_wa",   77'(bus.wb_addr_o),  77'd0);
    chk("rst_be",   77'(bus.wb_be_o),    77'd0);
    chk("rst_cnt",  77'(count),          77'd0);
    chk("rst_busy", 77'(busy),           77'd0);
    chk("rst_rdy",  77'(bus.in_ready_o), 77'd1);

    // Normal beats, dst 3, data 1..5, always-ready write port.
    add(1,0,0,3,3,64'd1,1, 1,0,64'd0,5'd0,8'h00,3'd0,0);
    add(1,0,0,3,3,64'd2,1, 1,1,64'd1,5'd3,8'hFF,3'd1,1);
    add(1,0,0,3,3,64'd3,1, 1,1,64'd2,5'd3,8'hFF,3'd1,1);
    add(1,0,0,3,3,64'd4,1, 1,1,64'd3,5'd3,8'hFF,3'd1,1);
    add(1,0,0,3,3,64'd5,1, 1,1,64'd4,5'd3,8'hFF,3'd1,1);
    add(0,0,0,3,3,64'd0,1, 1,1,64'd5,5'd3,8'hFF,3'd1,1);
    add(0,0,0,3,3,64'd0,1, 1,0,64'd0,5'd0,8'h00,3'd0,0);
    // Three sew=8 mask beats to dst 7 (upper data bits are noise), last on the third.
    add(1,1,0,0,7,64'hDEAD_0000_0000_00A5,1, 1,0,64'd0,5'd0,8'h00,3'd0,0);
    add(1,1,0,0,7,64'h0000_BEEF_0000_003C,1, 1,0,64'd0,5'd0,8'h00,3'd0,1);
    add(1,1,1,0,7,64'hFFFF_FFFF_FFFF_FF81,1, 1,0,64'd0,5'd0,8'h00,3'd0,1);
    add(0,0,0,0,0,64'd0,1, 1,1,64'h0000_0000_0081_3CA5,5'd7,8'h07,3'd1,1);
    add(0,0,0,0,0,64'd0,1, 1,0,64'd0,5'd0,8'h00,3'd0,0);
    // Two mask beats on dst 4, interrupted by a normal beat to dst 9.
    add(1,1,0,0,4,64'h0F,1,                  1,0,64'd0,5'd0,8'h00,3'd0,0);
    add(1,1,0,0,4,64'hAB00_0000_0000_00F0,1, 1,0,64'd0,5'd0,8'h00,3'd0,1);
    add(1,0,0,3,9,64'h55,1,                  0,0,64'd0,5'd0,8'h00,3'd0,1);
    add(1,0,0,3,9,64'h55,1,                  1,1,64'hF00F,5'd4,8'h03,3'd1,1);
    add(0,0,0,0,0,64'd0,1,                   1,1,64'h55,5'd9,8'hFF,3'd1,1);
    add(0,0,0,0,0,64'd0,1,                   1,0,64'd0,5'd0,8'h00,3'd0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].m, vecs[i].l, vecs[i].sew, vecs[i].dst, vecs[i].data, vecs[i].wr);
      #1;
      chk($sformatf("v%0d_rdy", i),  77'(bus.in_ready_o), 77'(vecs[i].e_rdy));
      chk($sformatf("v%0d_wv", i),   77'(bus.wb_valid_o), 77'(vecs[i].e_wv));
      chk($sformatf("v%0d_cnt", i),  77'(count),          77'(vecs[i].e_cnt));
      chk($sformatf("v%0d_busy", i), 77'(busy),           77'(vecs[i].e_busy));
      if (vecs[i].e_wv) begin
        chk($sformatf("v%0d_wd", i), 77'(bus.wb_data_o), 77'(vecs[i].e_wd));
        chk($sformatf("v%0d_wa", i), 77'(bus.wb_addr_o), 77'(vecs[i].e_wa));
        chk($sformatf("v%0d_be", i), 77'(bus.wb_be_o),   77'(vecs[i].e_be));
      end
      cycle();
    end

    // Backpressure: six beats offered to a stalled port, then drain.
    got.delete(); exp_q.delete();
    k = 0;
    for (int c = 0; c < 6; c++) begin
      logic acc;
      drive(1'b1, 1'b0, 1'b0, 3'd3, 5'd2, 64'h10 + 64'(k), 1'b0);
      #1;
      acc = bus.in_ready_o;
      cycle();
      if (acc) k++;
    end
    drive(1'b1, 1'b0, 1'b0, 3'd3, 5'd2, 64'h10 + 64'(k), 1'b0);
    #1;
    chk("bp_accepts",  77'(k),              77'd4);
    chk("bp_cnt_full", 77'(count),          77'd4);
    chk("bp_rdy_low",  77'(bus.in_ready_o), 77'd0);
    chk("bp_head_hold",77'(bus.wb_data_o),  77'h10);
    bus.wb_ready_i = 1'b1;
    #1;
    chk("bp_rdy_pushpop", 77'(bus.in_ready_o), 77'd1);
    cycle();
    chk("bp_cnt_pushpop", 77'(count),         77'd4);
    chk("bp_head_next",   77'(bus.wb_data_o), 77'h11);
    drive(1'b1, 1'b0, 1'b0, 3'd3, 5'd2, 64'h15, 1'b1);
    #1;
    cycle();
    chk("bp_cnt_pushpop2", 77'(count), 77'd4);
    drive(1'b0, 1'b0, 1'b0, 3'd3, 5'd2, 64'd0, 1'b1);
    for (int c = 0; c < 6; c++) cycle();
    for (int i = 0; i < 6; i++) exp_q.push_back({8'hFF, 5'd2, 64'h10 + 64'(i)});
    compare_got("bp_order");
    chk("bp_cnt_empty", 77'(count), 77'd0);

    // 32 sew=32 mask beats of 2'b10 auto-emit one full word.
    for (int c = 0; c < 32; c++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd2, 5'd6, 64'h1234_5678_9ABC_DEF2, 1'b1);
      #1;
      if (c == 0 || c == 31) chk($sformatf("full_rdy%0d", c), 77'(bus.in_ready_o), 77'd1);
      if (c == 31) chk("full_pre_cnt", 77'(count), 77'd0);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1);
    #1;
    chk("full_cnt",  77'(count),          77'd1);
    chk("full_wv",   77'(bus.wb_valid_o), 77'd1);
    chk("full_wd",   77'(bus.wb_data_o),  77'hAAAA_AAAA_AAAA_AAAA);
    chk("full_be",   77'(bus.wb_be_o),    77'hFF);
    chk("full_wa",   77'(bus.wb_addr_o),  77'd6);
    cycle();
    chk("full_drained_cnt",  77'(count), 77'd0);
    chk("full_drained_busy", 77'(busy),  77'd0);

    // Mask last beat into a full, stalled FIFO goes through FLUSH.
    got.delete(); exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd3, 5'd1, 64'h20 + 64'(c), 1'b0);
      #1;
      cycle();
    end
    drive(1'b1, 1'b1, 1'b1, 3'd0, 5'd8, 64'hFF00_0000_0000_005A, 1'b0);
    #1;
    chk("fl_mask_rdy", 77'(bus.in_ready_o), 77'd1);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 3'd3, 5'd1, 64'h99, 1'b0);
    #1;
    chk("fl_rdy0",  77'(bus.in_ready_o), 77'd0);
    chk("fl_cnt",   77'(count),          77'd4);
    chk("fl_busy",  77'(busy),           77'd1);
    cycle();
    chk("fl_rdy1",  77'(bus.in_ready_o), 77'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1);
    #1;
    cycle();
    chk("fl_cnt_after", 77'(count), 77'd4);
    for (int c = 0; c < 6; c++) cycle();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'hFF, 5'd1, 64'h20 + 64'(i)});
    exp_q.push_back({8'h01, 5'd8, 64'h5A});
    compare_got("fl_order");
    chk("fl_idle_rdy",  77'(bus.in_ready_o), 77'd1);
    chk("fl_idle_busy", 77'(busy),           77'd0);

    // Reset while accumulating discards the partial word.
    got.delete(); exp_q.delete();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd3, 64'h11, 1'b1);
    #1;
    cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 1'b1);
    #1;
    chk("ra_busy_pre", 77'(busy), 77'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("ra_cnt",  77'(count),          77'd0);
    chk("ra_busy", 77'(busy),           77'd0);
    chk("ra_rdy",  77'(bus.in_ready_o), 77'd1);
    for (int c = 0; c < 5; c++) cycle();
    chk("ra_no_write", 77'(got.size()), 77'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
